bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Sits directly upstream of the 7-segment decoder/scanner.
- Converts a binary count into packed BCD digits; each 4-bit digit drives the decoder's 4-bit data input.
- Start/done handshake; result held stable between conversions.

---
 rtl/bin2bcd_seq.sv | 187 ++++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// that feeds the 7-segment decoder/scanner with packed BCD digits.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high, highest priority
//   start    in   conversion request, sampled only while idle
//   bin_in   in   [BIN_W-1:0] binary value, captured with an accepted start
//   busy     out  high while the conversion is in progress
//   done     out  one-cycle pulse when bcd_out/overflow have been updated
//   bcd_out  out  [4*DIGITS-1:0] packed BCD, digit 0 in [3:0]
//   overflow out  value exceeded 10^DIGITS-1 (bcd_out saturated to all 9s)
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Adds 3 to every nibble that is 5 or more; nibbles are independent,
  // so no carry ever crosses a digit boundary.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end else begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic [BIN_W-1:0]   bin_shift_r;
  logic [BCD_W-1:0]   bcd_work_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_work_r;

  logic [BCD_W-1:0]   bcd_adj_s;
  logic [BCD_W-1:0]   bcd_shift_s;
  logic               ovf_nx_s;
  logic               last_shift_s;
  logic               busy_nx_s;
  logic               done_nx_s;

  // One double-dabble step: add-3 correction, then shift in the next bin MSB.
  // The bit leaving the top nibble means the value no longer fits in DIGITS.
  always_comb begin
    bcd_adj_s    = add3_all(bcd_work_r);
    bcd_shift_s  = {bcd_adj_s[BCD_W-2:0], bin_shift_r[BIN_W-1]};
    ovf_nx_s     = ovf_work_r | bcd_adj_s[BCD_W-1];
    last_shift_s = (cnt_r == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_shift_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so busy/done can be registered and
  // still line up with the state they describe.
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_nx_s)
      ST_SHIFT: begin
        busy_nx_s = 1'b1;
      end
      ST_DONE: begin
        done_nx_s = 1'b1;
      end
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx_s;
      done <= done_nx_s;
    end
  end

  // Conversion datapath; bcd_out/overflow are loaded only by the final
  // shift (the edge entering DONE) so the display sees a stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_shift_r <= '0;
      bcd_work_r  <= '0;
      cnt_r       <= '0;
      ovf_work_r  <= 1'b0;
      bcd_out     <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            bin_shift_r <= bin_in;
            bcd_work_r  <= '0;
            cnt_r       <= '0;
            ovf_work_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          bcd_work_r  <= bcd_shift_s;
          bin_shift_r <= {bin_shift_r[BIN_W-2:0], 1'b0};
          cnt_r       <= cnt_r + CNT_W'(1);
          ovf_work_r  <= ovf_nx_s;
          if (last_shift_s) begin
            overflow <= ovf_nx_s;
            if (ovf_nx_s) begin
              bcd_out <= {DIGITS{4'h9}};
            end else begin
              bcd_out <= bcd_shift_s;
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed-vector bench for bin2bcd_seq with hand-computed BCD results.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        overflow;

  int          n_vec;
  int          n_err;
  logic [23:0] exp_last;

  bin2bcd_seq #(
    .BIN_W  (20),
    .DIGITS (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  // 50 MHz clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion from IDLE. inj>0 pulses start (bin_in=777) during
  // shift cycle inj+1 to show it is ignored.
  task automatic run_conv(input logic [19:0] v, input logic [23:0] e_bcd,
                          input logic e_ovf, input int inj);
    int   busy_cnt;
    int   done_at;
    logic stable_ok;
    logic excl_ok;
    start  = 1'b1;
    bin_in = v;
    tick();
    start  = 1'b0;
    bin_in = 20'd0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    busy_cnt  = busy ? 1 : 0;
    done_at   = 0;
    stable_ok = 1'b1;
    excl_ok   = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done && busy) excl_ok = 1'b0;
      if (done) begin
        done_at = n;
        break;
      end
      if (busy) busy_cnt++;
      if (bcd_out !== exp_last) stable_ok = 1'b0;
      if (inj != 0 && n == inj) begin
        start  = 1'b1;
        bin_in = 20'd777;
      end else begin
        start  = 1'b0;
        bin_in = 20'd0;
      end
    end
    start = 1'b0;
    chk("latency_edges", done_at, 32'd20);
    chk("busy_cycles", busy_cnt, 32'd20);
    chk("hold_during_conv", {31'd0, stable_ok}, 32'd1);
    chk("busy_done_excl", {31'd0, excl_ok}, 32'd1);
    chk("bcd_out", {8'd0, bcd_out}, {8'd0, e_bcd});
    chk("overflow", {31'd0, overflow}, {31'd0, e_ovf});
    exp_last = e_bcd;
    tick();
    chk("done_single", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("bcd_hold", {8'd0, bcd_out}, {8'd0, e_bcd});
  endtask

  initial begin
    int dones;
    n_vec    = 0;
    n_err    = 0;
    exp_last = 24'h000000;

    // Reset with start asserted: nothing may start.
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 20'd1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_bcd", {8'd0, bcd_out}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    run_conv(20'd0,       24'h000000, 1'b0, 0);
    run_conv(20'd15,      24'h000015, 1'b0, 0);
    run_conv(20'd999999,  24'h999999, 1'b0, 0);
    run_conv(20'd1000000, 24'h999999, 1'b1, 0);
    run_conv(20'hFFFFF,   24'h999999, 1'b1, 0);
    run_conv(20'd42,      24'h000042, 1'b0, 0);
    run_conv(20'd123456,  24'h123456, 1'b0, 4);

    // Reset in the 10th shift cycle discards the conversion.
    start  = 1'b1;
    bin_in = 20'd654321;
    tick();
    start  = 1'b0;
    bin_in = 20'd0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_bcd", {8'd0, bcd_out}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 32'd0);
    exp_last = 24'h000000;
    run_conv(20'd88, 24'h000088, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
